// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives a 1-cycle-latency ROM and
// delivers one instruction per cycle to IF/ID through a 1-entry skid buffer.
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h00400000,
    parameter logic [31:0] RAM_BASE       = 32'h00400000,
    parameter int          RAM_ADDR_WIDTH = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_fault,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + (33'd4 << RAM_ADDR_WIDTH);

    state_t      r_state;
    logic [31:0] r_pc;
    logic        r_inflight;
    logic [31:0] r_inflight_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_inst;
    logic        r_skid_fault;
    logic        r_if_valid;
    logic [31:0] r_if_pc;
    logic [31:0] r_if_inst;
    logic        r_if_fault;

    logic        w_legal;
    logic [1:0]  w_occ;
    logic        w_consume;
    logic        w_room;
    logic        w_issue_ok;
    logic        w_req;
    logic        w_fault;
    logic        w_arr_valid;
    logic [31:0] w_arr_pc;
    logic [31:0] w_arr_inst;
    logic        w_arr_fault;
    logic        w_out_load;

    // Handshake: the IF output is a valid/stall pair; an entry is taken by ID
    // on any edge where if_valid=1 and stall=0, otherwise it holds unchanged.
    assign w_legal     = (r_pc[1:0] == 2'b00) && (r_pc >= RAM_BASE) && ({1'b0, r_pc} < RAM_END);
    assign w_occ       = {1'b0, r_if_valid} + {1'b0, r_skid_valid} + {1'b0, r_inflight};
    assign w_consume   = r_if_valid & ~stall;
    assign w_room      = (w_occ - {1'b0, w_consume}) < 2'd2;
    assign w_issue_ok  = (r_state == ST_RUN) & ~redirect_valid & w_room;
    assign w_req       = w_issue_ok & w_legal;
    // A fault waits for the in-flight response so program order is kept.
    assign w_fault     = w_issue_ok & ~w_legal & ~r_inflight;

    assign w_arr_valid = r_inflight | w_fault;
    assign w_arr_pc    = r_inflight ? r_inflight_pc : r_pc;
    assign w_arr_inst  = r_inflight ? imem_rdata : 32'd0;
    assign w_arr_fault = ~r_inflight;
    assign w_out_load  = ~r_if_valid | ~stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_BOOT;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'd0;
            r_skid_valid  <= 1'b0;
            r_skid_pc     <= 32'd0;
            r_skid_inst   <= 32'd0;
            r_skid_fault  <= 1'b0;
            r_if_valid    <= 1'b0;
            r_if_pc       <= 32'd0;
            r_if_inst     <= 32'd0;
            r_if_fault    <= 1'b0;
        end else if (redirect_valid) begin
            r_state      <= ST_RUN;
            r_pc         <= redirect_pc;
            r_inflight   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_if_valid   <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: r_state <= ST_RUN;
                ST_RUN:  if (w_fault) r_state <= ST_HALT;
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_BOOT;
            endcase

            r_inflight <= w_req;
            if (w_req) begin
                r_pc          <= r_pc + 32'd4;
                r_inflight_pc <= r_pc;
            end

            if (w_out_load) begin
                if (r_skid_valid) begin
                    r_if_valid   <= 1'b1;
                    r_if_pc      <= r_skid_pc;
                    r_if_inst    <= r_skid_inst;
                    r_if_fault   <= r_skid_fault;
                    r_skid_valid <= w_arr_valid;
                    if (w_arr_valid) begin
                        r_skid_pc    <= w_arr_pc;
                        r_skid_inst  <= w_arr_inst;
                        r_skid_fault <= w_arr_fault;
                    end
                end else if (w_arr_valid) begin
                    r_if_valid <= 1'b1;
                    r_if_pc    <= w_arr_pc;
                    r_if_inst  <= w_arr_inst;
                    r_if_fault <= w_arr_fault;
                end else begin
                    r_if_valid <= 1'b0;
                end
            end else if (w_arr_valid) begin
                // Output is held: occupancy limit guarantees the skid is free.
                r_skid_valid <= 1'b1;
                r_skid_pc    <= w_arr_pc;
                r_skid_inst  <= w_arr_inst;
                r_skid_fault <= w_arr_fault;
            end
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign if_valid    = r_if_valid;
    assign if_pc       = r_if_pc;
    assign if_inst     = r_if_inst;
    assign if_fault    = r_if_fault;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: a synchronous ROM model plus a linear
// sequence of steps with hand-computed expected PCs, words and flags.
module tb_inst_fetch_ctrl;

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] rom_q;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fault;
    logic [1:0]  dbg_state;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    inst_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (rom_q),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_inst        (if_inst),
        .if_fault       (if_fault),
        .o_dbg_state    (dbg_state)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    // ROM: data valid only in the cycle after a request, garbage otherwise.
    always @(posedge clk) rom_q <= imem_req ? rom_word(imem_addr) : 32'hDEADBEEF;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [31:0] pc, input logic f);
        chk({tag, ".valid"}, 32'(if_valid), 32'(v));
        if (v) begin
            chk({tag, ".pc"}, if_pc, pc);
            chk({tag, ".fault"}, 32'(if_fault), 32'(f));
            chk({tag, ".inst"}, if_inst, f ? 32'd0 : rom_word(pc));
        end
    endtask

    task automatic expect_req(input string tag, input logic r, input logic [31:0] addr);
        chk({tag, ".req"}, 32'(imem_req), 32'(r));
        if (r) chk({tag, ".addr"}, imem_addr, addr);
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
        repeat (3) tick();

        // Reset state and boot sequence
        reset = 1'b0; #1;
        chk("rst.state", 32'(dbg_state), 32'(S_BOOT));
        expect_req("rst", 1'b0, 32'd0);
        chk("rst.valid", 32'(if_valid), 32'd0);
        chk("rst.pc", if_pc, 32'd0);
        chk("rst.inst", if_inst, 32'd0);
        chk("rst.fault", 32'(if_fault), 32'd0);
        tick(); #1;
        chk("run.state", 32'(dbg_state), 32'(S_RUN));
        expect_req("first_req", 1'b1, 32'h00400000);
        expect_out("first_wait", 1'b0, 32'd0, 1'b0);
        tick(); #1;
        expect_req("second_req", 1'b1, 32'h00400004);
        expect_out("second_wait", 1'b0, 32'd0, 1'b0);
        tick(); #1;
        expect_out("first_out", 1'b1, 32'h00400000, 1'b0);
        expect_req("third_req", 1'b1, 32'h00400008);
        for (int i = 1; i <= 4; i++) begin
            tick(); #1;
            expect_out("stream", 1'b1, 32'h00400000 + 32'(4 * i), 1'b0);
            expect_req("stream", 1'b1, 32'h00400008 + 32'(4 * i));
        end

        // Stall for three cycles with one response landing in the skid
        stall = 1'b1; #1;
        expect_req("stall0", 1'b0, 32'd0);
        chk("stall0.addr", imem_addr, 32'h00400018);
        expect_out("stall0", 1'b1, 32'h00400010, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            tick(); #1;
            expect_out("stall_hold", 1'b1, 32'h00400010, 1'b0);
            expect_req("stall_hold", 1'b0, 32'd0);
            chk("stall_hold.addr", imem_addr, 32'h00400018);
        end
        stall = 1'b0; #1;
        expect_req("release", 1'b1, 32'h00400018);
        tick(); #1;
        expect_out("after_stall0", 1'b1, 32'h00400014, 1'b0);
        expect_req("after_stall0", 1'b1, 32'h0040001C);
        tick(); #1;
        expect_out("after_stall1", 1'b1, 32'h00400018, 1'b0);

        // Redirect while stalled with the skid full
        stall = 1'b1; #1;
        expect_req("fill_skid", 1'b0, 32'd0);
        tick(); #1;
        expect_out("skid_full", 1'b1, 32'h00400018, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h00400074; #1;
        expect_req("redir_cycle", 1'b0, 32'd0);
        tick();
        redirect_valid = 1'b0; redirect_pc = 32'd0; stall = 1'b0; #1;
        expect_out("redir_n1", 1'b0, 32'd0, 1'b0);
        expect_req("redir_n1", 1'b1, 32'h00400074);
        tick(); #1;
        expect_out("redir_n2", 1'b0, 32'd0, 1'b0);
        expect_req("redir_n2", 1'b1, 32'h00400078);
        tick(); #1;
        expect_out("redir_tgt", 1'b1, 32'h00400074, 1'b0);
        tick(); #1;
        expect_out("redir_tgt1", 1'b1, 32'h00400078, 1'b0);

        // Redirect beyond the ROM
        redirect_to(32'h00400800); #1;
        expect_req("oor_n1", 1'b0, 32'd0);
        expect_out("oor_n1", 1'b0, 32'd0, 1'b0);
        chk("oor_n1.state", 32'(dbg_state), 32'(S_RUN));
        tick(); #1;
        expect_out("oor_fault", 1'b1, 32'h00400800, 1'b1);
        expect_req("oor_fault", 1'b0, 32'd0);
        chk("oor_fault.state", 32'(dbg_state), 32'(S_HALT));
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            expect_out("halt_idle", 1'b0, 32'd0, 1'b0);
            expect_req("halt_idle", 1'b0, 32'd0);
            chk("halt_idle.state", 32'(dbg_state), 32'(S_HALT));
        end

        // Resume from HALT
        redirect_to(32'h00400000); #1;
        chk("resume.state", 32'(dbg_state), 32'(S_RUN));
        expect_req("resume", 1'b1, 32'h00400000);
        tick(); #1;
        expect_out("resume_wait", 1'b0, 32'd0, 1'b0);
        tick(); #1;
        expect_out("resume_out", 1'b1, 32'h00400000, 1'b0);

        // Misaligned target
        redirect_to(32'h00400002); #1;
        expect_req("misal_n1", 1'b0, 32'd0);
        tick(); #1;
        expect_out("misal_fault", 1'b1, 32'h00400002, 1'b1);
        expect_req("misal_fault", 1'b0, 32'd0);
        chk("misal.state", 32'(dbg_state), 32'(S_HALT));

        // Run off the top of the ROM
        redirect_to(32'h004007F8); #1;
        expect_req("top_n1", 1'b1, 32'h004007F8);
        tick(); #1;
        expect_req("top_n2", 1'b1, 32'h004007FC);
        tick(); #1;
        expect_out("top_7f8", 1'b1, 32'h004007F8, 1'b0);
        expect_req("top_end", 1'b0, 32'd0);
        tick(); #1;
        expect_out("top_7fc", 1'b1, 32'h004007FC, 1'b0);
        expect_req("top_end2", 1'b0, 32'd0);
        tick(); #1;
        expect_out("top_fault", 1'b1, 32'h00400800, 1'b1);
        chk("top.state", 32'(dbg_state), 32'(S_HALT));

        // Reset mid-stream with a fetch in flight
        redirect_to(32'h00400000);
        tick(); tick(); tick(); #1;
        expect_out("pre_rst", 1'b1, 32'h00400004, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        expect_out("mid_rst", 1'b0, 32'd0, 1'b0);
        expect_req("mid_rst", 1'b0, 32'd0);
        chk("mid_rst.state", 32'(dbg_state), 32'(S_BOOT));
        tick(); #1;
        expect_req("rst_req", 1'b1, 32'h00400000);
        expect_out("rst_req", 1'b0, 32'd0, 1'b0);
        tick(); #1;
        expect_out("rst_wait", 1'b0, 32'd0, 1'b0);
        tick(); #1;
        expect_out("rst_out0", 1'b1, 32'h00400000, 1'b0);
        tick(); #1;
        expect_out("rst_out1", 1'b1, 32'h00400004, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
